// File: rtl/cl_dram_matrix_sched.sv
// cl_dram_matrix_sched: walks an N_ROWS x N_COLS output grid. For every
// element it programs the dot-product engine (mat1/mat2/dst bases, then
// start) and polls the engine's finished bit before moving to the next one.
module cl_dram_matrix_sched #(
  parameter int DIM_W       = 5,
  parameter int ACK_TIMEOUT = 64,
  parameter int POLL_GAP    = 4,
  parameter int ELEM_BYTES  = 4,
  parameter int DST_BYTES   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        h_wr,
  input  logic        h_rd,
  input  logic [7:0]  h_addr,
  input  logic [31:0] h_wdata,
  output logic        h_ack,
  output logic [31:0] h_rdata,
  output logic        e_wr,
  output logic        e_rd,
  output logic [7:0]  e_addr,
  output logic [31:0] e_wdata,
  input  logic        e_ack,
  input  logic [31:0] e_rdata,
  output logic        busy,
  output logic        irq_done
);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(POLL_GAP + 1);

  typedef enum logic [2:0] {
    IDLE, WR_ISSUE, WR_ACK, RD_ISSUE, RD_ACK, GAP, ADVANCE
  } state_t;

  state_t             state;
  logic [2:0]         k;
  logic [DIM_W-1:0]   i, j, n_rows, n_cols;
  logic [63:0]        a_base, b_base, c_base, a_cur, b_cur, c_cur;
  logic [31:0]        a_stride;
  logic [15:0]        jobs_done;
  logic               done_q, err_q, abort_pend;
  logic [AW-1:0]      ack_cnt;
  logic [GW-1:0]      gap_cnt;

  logic               ctrl_wr, start_req, abort_req, last;
  logic [DIM_W-1:0]   i_nxt, j_nxt;
  logic [63:0]        a_nxt, b_nxt, c_nxt;
  logic [31:0]        rd_mux;
  logic               unused_rdata;

  assign busy         = (state != IDLE);
  assign ctrl_wr      = h_wr && (h_addr == 8'h00);
  assign start_req    = ctrl_wr && h_wdata[0];
  // An abort written in the same cycle it is acted upon still counts.
  assign abort_req    = abort_pend || (ctrl_wr && h_wdata[1]);
  assign unused_rdata = ^e_rdata[31:1];

  // Engine cfg register for each of the seven per-job writes.
  function automatic logic [7:0] wr_addr(input logic [2:0] kk);
    case (kk)
      3'd0:    wr_addr = 8'h10;
      3'd1:    wr_addr = 8'h14;
      3'd2:    wr_addr = 8'h18;
      3'd3:    wr_addr = 8'h1C;
      3'd4:    wr_addr = 8'h20;
      3'd5:    wr_addr = 8'h24;
      default: wr_addr = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] wr_data(input logic [2:0] kk,
                                          input logic [63:0] a, b, c);
    case (kk)
      3'd0:    wr_data = a[31:0];
      3'd1:    wr_data = a[63:32];
      3'd2:    wr_data = b[31:0];
      3'd3:    wr_data = b[63:32];
      3'd4:    wr_data = c[31:0];
      3'd5:    wr_data = c[63:32];
      default: wr_data = 32'd1;
    endcase
  endfunction

  // Next grid position and addresses, used when leaving ADVANCE.
  always_comb begin
    a_nxt = a_cur;
    b_nxt = b_cur + 64'(ELEM_BYTES);
    c_nxt = c_cur + 64'(DST_BYTES);
    i_nxt = i;
    j_nxt = j + 1'b1;
    last  = 1'b0;
    if (j == n_cols - DIM_W'(1)) begin
      j_nxt = '0;
      b_nxt = b_base;
      if (i == n_rows - DIM_W'(1)) last = 1'b1;
      else begin
        i_nxt = i + 1'b1;
        a_nxt = a_cur + {32'h0, a_stride};
      end
    end
  end

  // Host read decode.
  always_comb begin
    rd_mux = 32'h0;
    case (h_addr)
      8'h04: rd_mux = {16'h0, 5'h0, state, 5'h0, err_q, done_q, busy};
      8'h08: rd_mux = {{(32-DIM_W){1'b0}}, n_rows};
      8'h0C: rd_mux = {{(32-DIM_W){1'b0}}, n_cols};
      8'h10: rd_mux = a_base[31:0];
      8'h14: rd_mux = a_base[63:32];
      8'h18: rd_mux = b_base[31:0];
      8'h1C: rd_mux = b_base[63:32];
      8'h20: rd_mux = c_base[31:0];
      8'h24: rd_mux = c_base[63:32];
      8'h28: rd_mux = a_stride;
      8'h2C: rd_mux = {16'h0, jobs_done};
      default: rd_mux = 32'h0;
    endcase
  end

  // Host ack/readback, one cycle after the access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_ack   <= 1'b0;
      h_rdata <= 32'h0;
    end else begin
      h_ack   <= h_wr | h_rd;
      h_rdata <= h_rd ? rd_mux : 32'h0;
    end
  end

  // Job configuration; frozen while a sequence runs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_rows <= '0; n_cols <= '0; a_stride <= 32'h0;
      a_base <= 64'h0; b_base <= 64'h0; c_base <= 64'h0;
    end else if (h_wr && state == IDLE) begin
      case (h_addr)
        8'h08: n_rows          <= h_wdata[DIM_W-1:0];
        8'h0C: n_cols          <= h_wdata[DIM_W-1:0];
        8'h10: a_base[31:0]    <= h_wdata;
        8'h14: a_base[63:32]   <= h_wdata;
        8'h18: b_base[31:0]    <= h_wdata;
        8'h1C: b_base[63:32]   <= h_wdata;
        8'h20: c_base[31:0]    <= h_wdata;
        8'h24: c_base[63:32]   <= h_wdata;
        8'h28: a_stride        <= h_wdata;
        default: ;
      endcase
    end
  end

  // Sequencer: strobes are launched on the edge entering an ISSUE state, so
  // they are high exactly while the FSM sits in that state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE; k <= 3'd0; i <= '0; j <= '0;
      a_cur <= 64'h0; b_cur <= 64'h0; c_cur <= 64'h0;
      jobs_done <= 16'h0; done_q <= 1'b0; err_q <= 1'b0; abort_pend <= 1'b0;
      ack_cnt <= '0; gap_cnt <= '0; irq_done <= 1'b0;
      e_wr <= 1'b0; e_rd <= 1'b0; e_addr <= 8'h0; e_wdata <= 32'h0;
    end else begin
      irq_done <= 1'b0;
      e_wr     <= 1'b0;
      e_rd     <= 1'b0;
      if (busy && ctrl_wr && h_wdata[1]) abort_pend <= 1'b1;
      case (state)
        IDLE: if (start_req) begin
          done_q <= 1'b0; err_q <= 1'b0; jobs_done <= 16'h0;
          a_cur <= a_base; b_cur <= b_base; c_cur <= c_base;
          i <= '0; j <= '0; k <= 3'd0;
          if (n_rows == '0 || n_cols == '0) begin
            done_q   <= 1'b1;
            irq_done <= 1'b1;
          end else begin
            e_wr    <= 1'b1;
            e_addr  <= wr_addr(3'd0);
            e_wdata <= wr_data(3'd0, a_base, b_base, c_base);
            state   <= WR_ISSUE;
          end
        end
        WR_ISSUE: begin ack_cnt <= '0; state <= WR_ACK; end
        RD_ISSUE: begin ack_cnt <= '0; state <= RD_ACK; end
        WR_ACK, RD_ACK: begin
          if (e_ack) begin
            if (abort_req) begin
              state <= IDLE; done_q <= 1'b0; err_q <= 1'b0; abort_pend <= 1'b0;
            end else if (state == WR_ACK && k != 3'd6) begin
              k       <= k + 3'd1;
              e_wr    <= 1'b1;
              e_addr  <= wr_addr(k + 3'd1);
              e_wdata <= wr_data(k + 3'd1, a_cur, b_cur, c_cur);
              state   <= WR_ISSUE;
            end else if (state == WR_ACK) begin
              e_rd <= 1'b1; e_addr <= 8'h00; e_wdata <= 32'h0;
              state <= RD_ISSUE;
            end else if (e_rdata[0]) begin
              state <= ADVANCE;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
            // Engine went silent; a pending abort still wins over error.
            state <= IDLE; abort_pend <= 1'b0; done_q <= 1'b0;
            err_q <= !abort_req;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        GAP: begin
          if (abort_req) begin
            state <= IDLE; done_q <= 1'b0; err_q <= 1'b0; abort_pend <= 1'b0;
          end else if (gap_cnt == GW'(POLL_GAP - 1)) begin
            e_rd <= 1'b1; e_addr <= 8'h00; e_wdata <= 32'h0;
            state <= RD_ISSUE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ADVANCE: begin
          jobs_done <= jobs_done + 16'd1;
          a_cur <= a_nxt; b_cur <= b_nxt; c_cur <= c_nxt;
          i <= i_nxt; j <= j_nxt; k <= 3'd0;
          if (last) begin
            // Completion beats an abort that lands on the final job.
            done_q <= 1'b1; irq_done <= 1'b1; abort_pend <= 1'b0;
            state  <= IDLE;
          end else if (abort_req) begin
            state <= IDLE; done_q <= 1'b0; err_q <= 1'b0; abort_pend <= 1'b0;
          end else begin
            e_wr    <= 1'b1;
            e_addr  <= wr_addr(3'd0);
            e_wdata <= wr_data(3'd0, a_nxt, b_nxt, c_nxt);
            state   <= WR_ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cl_dram_matrix_sched.sv
// Directed bench for cl_dram_matrix_sched with a small engine responder.
module tb_cl_dram_matrix_sched;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        h_wr = 1'b0, h_rd = 1'b0;
  logic [7:0]  h_addr = 8'h0;
  logic [31:0] h_wdata = 32'h0;
  logic        h_ack, e_wr, e_rd, busy, irq_done;
  logic [31:0] h_rdata, e_wdata;
  logic [7:0]  e_addr;
  logic        e_ack = 1'b0;
  logic [31:0] e_rdata = 32'h0;

  int vec_cnt = 0, err_cnt = 0;

  // engine responder state (written only by the responder)
  int          wr_n = 0, rd_n = 0, irq_n = 0, cyc = 0, polls = 0;
  logic [7:0]  wr_addr_log [512];
  logic [31:0] wr_data_log [512];
  int          rd_cyc_log  [512];
  logic        ack_pend = 1'b0, fin_pend = 1'b0;
  // responder knobs (written only by the test tasks)
  int          finish_poll = 1;
  int          drop_wr = 0;

  cl_dram_matrix_sched dut (
    .clk(clk), .rst_n(rst_n),
    .h_wr(h_wr), .h_rd(h_rd), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_rdata(h_rdata),
    .e_wr(e_wr), .e_rd(e_rd), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_ack(e_ack), .e_rdata(e_rdata),
    .busy(busy), .irq_done(irq_done)
  );

  always #5 clk = ~clk;

  // Engine: acks the cycle after each strobe; finishes on poll finish_poll.
  always @(negedge clk) begin
    e_ack    = ack_pend;
    e_rdata  = {31'h0, fin_pend};
    ack_pend = 1'b0;
    fin_pend = 1'b0;
    if (irq_done === 1'b1) irq_n++;
    if (e_wr === 1'b1) begin
      wr_addr_log[wr_n] = e_addr;
      wr_data_log[wr_n] = e_wdata;
      wr_n++;
      polls = 0;
      if (wr_n != drop_wr) ack_pend = 1'b1;
    end
    if (e_rd === 1'b1) begin
      rd_cyc_log[rd_n] = cyc;
      rd_n++;
      polls++;
      ack_pend = 1'b1;
      if (polls >= finish_poll) fin_pend = 1'b1;
    end
    cyc++;
  end

  task automatic host_write(input logic [7:0] a, input logic [31:0] d);
    h_wr = 1'b1; h_addr = a; h_wdata = d;
    @(negedge clk);
    h_wr = 1'b0; h_addr = 8'h0; h_wdata = 32'h0;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [31:0] d, output logic ack);
    h_rd = 1'b1; h_addr = a;
    @(negedge clk);
    h_rd = 1'b0; h_addr = 8'h0;
    d = h_rdata; ack = h_ack;
  endtask

  task automatic cfg(input int nr, input int nc, input logic [31:0] a, b, c, stride);
    host_write(8'h08, nr); host_write(8'h0C, nc);
    host_write(8'h10, a); host_write(8'h14, 32'h0);
    host_write(8'h18, b); host_write(8'h1C, 32'h0);
    host_write(8'h20, c); host_write(8'h24, 32'h0);
    host_write(8'h28, stride);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s: busy=%b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic ack;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({h_ack, h_rdata, e_wr, e_rd, e_addr, e_wdata, busy, irq_done} !== 76'h0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %h, required 0",
               {h_ack, h_rdata, e_wr, e_rd, e_addr, e_wdata, busy, irq_done});
    end
    rst_n = 1'b1;
    @(negedge clk);
    host_read(8'h04, d, ack);
    vec_cnt++;
    if ({ack, d} !== {1'b1, 32'h0}) begin
      err_cnt++; $display("FAIL reset_status: ack=%b data=%h, required ack=1 data=0", ack, d);
    end
    host_read(8'h2C, d, ack);
    vec_cnt++;
    if (d !== 32'h0) begin err_cnt++; $display("FAIL reset_jobs: got %h, required 0", d); end
  endtask

  task automatic test_single_job();
    logic [7:0]  ea [7];
    logic [31:0] ed [7];
    logic [31:0] d; logic ack;
    int w0, r0, q0;
    ea = '{8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h00};
    ed = '{32'h1000, 32'h0, 32'h2000, 32'h0, 32'h3000, 32'h0, 32'h1};
    cfg(1, 1, 32'h1000, 32'h2000, 32'h3000, 32'h0);
    finish_poll = 3;
    w0 = wr_n; r0 = rd_n; q0 = irq_n;
    host_write(8'h00, 32'h1);
    wait_idle(400, "single_idle");
    vec_cnt++;
    if (wr_n - w0 != 7) begin err_cnt++; $display("FAIL single_wr_count: got %0d, required 7", wr_n - w0); end
    for (int k = 0; k < 7; k++) begin
      vec_cnt++;
      if ({wr_addr_log[w0+k], wr_data_log[w0+k]} !== {ea[k], ed[k]}) begin
        err_cnt++;
        $display("FAIL single_wr%0d: got %h=%h, required %h=%h", k,
                 wr_addr_log[w0+k], wr_data_log[w0+k], ea[k], ed[k]);
      end
    end
    vec_cnt++;
    if (rd_n - r0 != 3) begin err_cnt++; $display("FAIL single_rd_count: got %0d, required 3", rd_n - r0); end
    for (int p = 1; p < 3; p++) begin
      vec_cnt++;
      if (rd_cyc_log[r0+p] - rd_cyc_log[r0+p-1] != 6) begin
        err_cnt++;
        $display("FAIL single_poll_gap%0d: got %0d cycles, required 6", p,
                 rd_cyc_log[r0+p] - rd_cyc_log[r0+p-1]);
      end
    end
    vec_cnt++;
    if (irq_n - q0 != 1) begin err_cnt++; $display("FAIL single_irq: got %0d pulses, required 1", irq_n - q0); end
    host_read(8'h04, d, ack);
    vec_cnt++;
    if (d !== 32'h2) begin err_cnt++; $display("FAIL single_status: got %h, required 2", d); end
    host_read(8'h2C, d, ack);
    vec_cnt++;
    if (d !== 32'h1) begin err_cnt++; $display("FAIL single_jobs: got %h, required 1", d); end
  endtask

  task automatic test_multi_job();
    logic [31:0] ed [7];
    logic [7:0]  ea [7];
    logic [31:0] d; logic ack;
    int w0, q0;
    ea = '{8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h00};
    cfg(2, 3, 32'h1000, 32'h2000, 32'h3000, 32'h40);
    finish_poll = 1;
    w0 = wr_n; q0 = irq_n;
    host_write(8'h00, 32'h1);
    wait_idle(600, "multi_idle");
    vec_cnt++;
    if (wr_n - w0 != 42) begin err_cnt++; $display("FAIL multi_wr_count: got %0d, required 42", wr_n - w0); end
    for (int n = 0; n < 6; n++) begin
      ed = '{32'h1000 + 32'(n / 3) * 32'h40, 32'h0, 32'h2000 + 32'(n % 3) * 32'h4, 32'h0,
             32'h3000 + 32'(n) * 32'h8, 32'h0, 32'h1};
      for (int k = 0; k < 7; k++) begin
        vec_cnt++;
        if ({wr_addr_log[w0+7*n+k], wr_data_log[w0+7*n+k]} !== {ea[k], ed[k]}) begin
          err_cnt++;
          $display("FAIL multi_job%0d_wr%0d: got %h=%h, required %h=%h", n, k,
                   wr_addr_log[w0+7*n+k], wr_data_log[w0+7*n+k], ea[k], ed[k]);
        end
      end
    end
    vec_cnt++;
    if (irq_n - q0 != 1) begin err_cnt++; $display("FAIL multi_irq: got %0d pulses, required 1", irq_n - q0); end
    host_read(8'h2C, d, ack);
    vec_cnt++;
    if (d !== 32'h6) begin err_cnt++; $display("FAIL multi_jobs: got %h, required 6", d); end
  endtask

  task automatic test_timeout();
    logic [31:0] d; logic ack;
    int w0, r0, q0, seen, n, c;
    cfg(1, 1, 32'h1000, 32'h2000, 32'h3000, 32'h0);
    w0 = wr_n; r0 = rd_n; q0 = irq_n;
    drop_wr = wr_n + 3;
    host_write(8'h00, 32'h1);
    seen = 0; n = 0;
    while (seen < 3 && n < 200) begin
      if (e_wr === 1'b1) seen++;
      if (seen < 3) begin @(negedge clk); n++; end
    end
    vec_cnt++;
    if (seen != 3) begin err_cnt++; $display("FAIL timeout_third_wr: saw %0d writes, required 3", seen); end
    c = 0;
    while (c < 200) begin
      @(negedge clk);
      if (busy === 1'b1) c++; else break;
    end
    vec_cnt++;
    if (c != 64) begin err_cnt++; $display("FAIL timeout_cycles: busy %0d cycles after strobe, required 64", c); end
    repeat (10) @(negedge clk);
    vec_cnt++;
    if ((wr_n - w0 != 3) || (rd_n - r0 != 0)) begin
      err_cnt++; $display("FAIL timeout_strobes: wr=%0d rd=%0d, required wr=3 rd=0", wr_n - w0, rd_n - r0);
    end
    vec_cnt++;
    if (irq_n - q0 != 0) begin err_cnt++; $display("FAIL timeout_irq: got %0d pulses, required 0", irq_n - q0); end
    host_read(8'h04, d, ack);
    vec_cnt++;
    if (d !== 32'h4) begin err_cnt++; $display("FAIL timeout_status: got %h, required 4", d); end
    drop_wr = 0;
  endtask

  task automatic test_abort();
    logic [31:0] d; logic ack;
    int w0, r0, q0, w1, nw, n;
    cfg(2, 3, 32'h1000, 32'h2000, 32'h3000, 32'h40);
    finish_poll = 3;
    w0 = wr_n; r0 = rd_n; q0 = irq_n;
    host_write(8'h00, 32'h1);
    nw = 0; n = 0;
    while (!(nw >= 14 && e_rd === 1'b1) && n < 400) begin
      if (e_wr === 1'b1) nw++;
      @(negedge clk); n++;
    end
    vec_cnt++;
    if (!(nw >= 14 && e_rd === 1'b1)) begin
      err_cnt++; $display("FAIL abort_reach_job2_poll: writes seen %0d, required 14 then a read", nw);
    end
    host_write(8'h00, 32'h2);
    wait_idle(200, "abort_idle");
    vec_cnt++;
    if ((wr_n - w0 != 14) || (rd_n - r0 != 4)) begin
      err_cnt++; $display("FAIL abort_strobes: wr=%0d rd=%0d, required wr=14 rd=4", wr_n - w0, rd_n - r0);
    end
    vec_cnt++;
    if (irq_n - q0 != 0) begin err_cnt++; $display("FAIL abort_irq: got %0d pulses, required 0", irq_n - q0); end
    host_read(8'h04, d, ack);
    vec_cnt++;
    if (d !== 32'h0) begin err_cnt++; $display("FAIL abort_status: got %h, required 0", d); end
    host_read(8'h2C, d, ack);
    vec_cnt++;
    if (d !== 32'h1) begin err_cnt++; $display("FAIL abort_jobs: got %h, required 1", d); end
    // rerun from job 0
    finish_poll = 1;
    w1 = wr_n;
    host_write(8'h00, 32'h1);
    wait_idle(600, "rerun_idle");
    vec_cnt++;
    if ({wr_addr_log[w1], wr_data_log[w1], wr_addr_log[w1+2], wr_data_log[w1+2],
         wr_addr_log[w1+4], wr_data_log[w1+4]} !==
        {8'h10, 32'h1000, 8'h18, 32'h2000, 8'h20, 32'h3000}) begin
      err_cnt++;
      $display("FAIL rerun_job0: got a=%h b=%h c=%h, required a=1000 b=2000 c=3000",
               wr_data_log[w1], wr_data_log[w1+2], wr_data_log[w1+4]);
    end
    vec_cnt++;
    if (wr_n - w1 != 42) begin err_cnt++; $display("FAIL rerun_wr_count: got %0d, required 42", wr_n - w1); end
    host_read(8'h2C, d, ack);
    vec_cnt++;
    if (d !== 32'h6) begin err_cnt++; $display("FAIL rerun_jobs: got %h, required 6", d); end
  endtask

  task automatic test_zero_and_busy_writes();
    logic [31:0] d; logic ack;
    int w0, r0, q0;
    cfg(2, 0, 32'h1000, 32'h2000, 32'h3000, 32'h0);
    w0 = wr_n; r0 = rd_n; q0 = irq_n;
    host_write(8'h00, 32'h1);
    vec_cnt++;
    if ({irq_done, busy} !== 2'b10) begin
      err_cnt++; $display("FAIL zero_irq_next_cycle: irq=%b busy=%b, required irq=1 busy=0", irq_done, busy);
    end
    @(negedge clk);
    vec_cnt++;
    if (irq_done !== 1'b0) begin err_cnt++; $display("FAIL zero_irq_width: irq=%b, required 0", irq_done); end
    host_read(8'h04, d, ack);
    vec_cnt++;
    if (d !== 32'h2) begin err_cnt++; $display("FAIL zero_status: got %h, required 2", d); end
    vec_cnt++;
    if ((wr_n - w0 != 0) || (rd_n - r0 != 0) || (irq_n - q0 != 1)) begin
      err_cnt++; $display("FAIL zero_strobes: wr=%0d rd=%0d irq=%0d, required 0 0 1",
                          wr_n - w0, rd_n - r0, irq_n - q0);
    end
    // config and start writes during a run
    cfg(1, 1, 32'h1000, 32'h2000, 32'h3000, 32'h0);
    finish_poll = 3;
    w0 = wr_n;
    host_write(8'h00, 32'h1);
    host_write(8'h10, 32'h9000);
    host_write(8'h00, 32'h1);
    wait_idle(400, "busywr_idle");
    vec_cnt++;
    if (wr_n - w0 != 7) begin err_cnt++; $display("FAIL busywr_wr_count: got %0d, required 7", wr_n - w0); end
    vec_cnt++;
    if (wr_data_log[w0] !== 32'h1000) begin
      err_cnt++; $display("FAIL busywr_mat1: got %h, required 1000", wr_data_log[w0]);
    end
    host_read(8'h10, d, ack);
    vec_cnt++;
    if (d !== 32'h1000) begin err_cnt++; $display("FAIL busywr_abase_reg: got %h, required 1000", d); end
    host_read(8'h2C, d, ack);
    vec_cnt++;
    if (d !== 32'h1) begin err_cnt++; $display("FAIL busywr_jobs: got %h, required 1", d); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d; logic ack;
    int strobes;
    cfg(1, 1, 32'h1000, 32'h2000, 32'h3000, 32'h0);
    host_write(8'h00, 32'h1);
    vec_cnt++;
    if (e_wr !== 1'b1) begin err_cnt++; $display("FAIL midrst_in_wr_issue: e_wr=%b, required 1", e_wr); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vec_cnt++;
    if ({h_ack, h_rdata, e_wr, e_rd, e_addr, e_wdata, busy, irq_done} !== 76'h0) begin
      err_cnt++;
      $display("FAIL midrst_outputs: got %h, required 0",
               {h_ack, h_rdata, e_wr, e_rd, e_addr, e_wdata, busy, irq_done});
    end
    host_read(8'h04, d, ack);
    vec_cnt++;
    if (d !== 32'h0) begin err_cnt++; $display("FAIL midrst_status: got %h, required 0", d); end
    strobes = 0;
    repeat (30) begin
      @(negedge clk);
      if (e_wr === 1'b1 || e_rd === 1'b1) strobes++;
    end
    vec_cnt++;
    if (strobes != 0) begin err_cnt++; $display("FAIL midrst_quiet: %0d strobes, required 0", strobes); end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_multi_job();
    test_timeout();
    test_abort();
    test_zero_and_busy_writes();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
